// File: rtl/l2_tcdm_responder_if.sv
// TCDM request/grant/r_valid bus between a master port and the L2 responder.
interface l2_tcdm_responder_if;
  logic        req;
  logic [31:0] add;
  logic        wen;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic        gnt;
  logic        r_valid;
  logic [31:0] r_rdata;
  logic        r_opc;

  modport master (
    output req, add, wen, wdata, be,
    input  gnt, r_valid, r_rdata, r_opc
  );

  modport slave (
    input  req, add, wen, wdata, be,
    output gnt, r_valid, r_rdata, r_opc
  );
endinterface

// File: rtl/l2_tcdm_responder.sv
// Target-side TCDM endpoint for a private L2 bank: grants requests, drives the SRAM macro
// and returns in-order responses a fixed READ_LATENCY cycles after each grant.
module l2_tcdm_responder #(
  parameter logic [31:0] BASE_ADDR      = 32'h1C00_0000,
  parameter int unsigned MEM_ADDR_WIDTH = 12,
  parameter int unsigned READ_LATENCY   = 1,
  parameter logic [31:0] ERR_RDATA      = 32'hBADA_CCE5
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  l2_tcdm_responder_if.slave        bus,
  input  logic                      mem_busy_i,
  output logic                      mem_csn_o,
  output logic                      mem_wen_o,
  output logic [MEM_ADDR_WIDTH-1:0] mem_add_o,
  output logic [3:0]                mem_be_o,
  output logic [31:0]               mem_wdata_o,
  input  logic [31:0]               mem_rdata_i,
  output logic [15:0]               err_cnt_o
);

  // Bank size in bytes; 33 bits so the compare cannot overflow.
  localparam logic [32:0] BankBytes = 33'd4 << MEM_ADDR_WIDTH;

  logic [31:0] offset;
  logic        in_range;
  logic        granted;

  // Per-stage response tags: valid, error, and read (data comes from the SRAM).
  logic [READ_LATENCY-1:0] pipe_valid_q;
  logic [READ_LATENCY-1:0] pipe_err_q;
  logic [READ_LATENCY-1:0] pipe_rd_q;
  logic                    rsp_valid;
  logic                    rsp_err;
  logic                    rsp_rd;
  logic [15:0]             err_cnt_q;

  // Only the word-address bits of the offset reach the SRAM.
  logic unused_offset;
  assign unused_offset = ^{offset[1:0], offset[31:MEM_ADDR_WIDTH+2]};

  // Range check, grant and SRAM drive, all combinational in the request cycle.
  always_comb begin
    offset      = bus.add - BASE_ADDR;
    in_range    = (bus.add >= BASE_ADDR) && ({1'b0, offset} < BankBytes);
    granted     = bus.req & ~rst_i & (~mem_busy_i | ~in_range);
    bus.gnt     = granted;
    mem_csn_o   = ~(granted & in_range);
    mem_wen_o   = (granted & in_range) ? bus.wen : 1'b1;
    mem_add_o   = offset[MEM_ADDR_WIDTH+1:2];
    mem_be_o    = bus.be;
    mem_wdata_o = bus.wdata;
  end

  // Response shift register; stage 0 reloads every cycle so idle cycles carry valid=0.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pipe_valid_q <= '0;
      pipe_err_q   <= '0;
      pipe_rd_q    <= '0;
    end else begin
      pipe_valid_q[0] <= granted;
      pipe_err_q[0]   <= granted & ~in_range;
      pipe_rd_q[0]    <= granted & bus.wen;
      for (int i = 1; i < int'(READ_LATENCY); i++) begin
        pipe_valid_q[i] <= pipe_valid_q[i-1];
        pipe_err_q[i]   <= pipe_err_q[i-1];
        pipe_rd_q[i]    <= pipe_rd_q[i-1];
      end
    end
  end

  // Response outputs are zero whenever no response is presented.
  always_comb begin
    rsp_valid   = pipe_valid_q[READ_LATENCY-1];
    rsp_err     = pipe_err_q[READ_LATENCY-1];
    rsp_rd      = pipe_rd_q[READ_LATENCY-1];
    bus.r_valid = rsp_valid;
    bus.r_opc   = rsp_valid & rsp_err;
    bus.r_rdata = '0;
    if (rsp_valid) begin
      if (rsp_err) begin
        bus.r_rdata = ERR_RDATA;
      end else if (rsp_rd) begin
        bus.r_rdata = mem_rdata_i;
      end
    end
  end

  // Saturating count of error responses.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_cnt_q <= '0;
    end else if (rsp_valid && rsp_err && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign err_cnt_o = err_cnt_q;

endmodule
